// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: captures ALU results and flags, resolves conditional
// branches, and buffers beats for memory/writeback in a 2-entry skid buffer.
// The head entry is also exposed for operand forwarding back to execute.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush_in,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_bga,
    input  logic              alu_bea,
    input  logic [REG_W-1:0]  in_dreg,
    input  logic              in_we,
    input  logic [2:0]        in_brop,
    input  logic [DATA_W-1:0] in_btarget,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_dreg,
    output logic              out_we,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_dreg,
    output logic [DATA_W-1:0] fwd_data
);

    localparam logic [1:0] StEmpty = 2'b00;
    localparam logic [1:0] StOne   = 2'b01;
    localparam logic [1:0] StTwo   = 2'b10;

    localparam logic [2:0] BrNone = 3'b000;
    localparam logic [2:0] BrBeq  = 3'b001;
    localparam logic [2:0] BrBne  = 3'b010;
    localparam logic [2:0] BrBgt  = 3'b011;
    localparam logic [2:0] BrBge  = 3'b100;
    localparam logic [2:0] BrBlt  = 3'b101;
    localparam logic [2:0] BrBle  = 3'b110;
    localparam logic [2:0] BrJump = 3'b111;

    logic [1:0]        state_q, state_d;
    logic              inReady_q, inReady_d;
    logic [DATA_W-1:0] mainResult_q, mainResult_d;
    logic [REG_W-1:0]  mainDreg_q, mainDreg_d;
    logic              mainWe_q, mainWe_d;
    logic [DATA_W-1:0] skidResult_q, skidResult_d;
    logic [REG_W-1:0]  skidDreg_q, skidDreg_d;
    logic              skidWe_q, skidWe_d;
    logic              branchTaken_q, branchTaken_d;
    logic [DATA_W-1:0] branchAddr_q, branchAddr_d;

    logic push;
    logic pop;
    logic storeWe;
    logic branchCond;

    assign out_valid = (state_q != StEmpty);
    assign push      = in_valid & inReady_q & ~flush_in;
    assign pop       = out_valid & out_ready;
    assign storeWe   = in_we & (in_dreg != '0);

    // Decode the branch condition from the ALU flags (only acted on when pushed)
    always_comb begin
        branchCond = 1'b0;
        unique case (in_brop)
            BrNone: branchCond = 1'b0;
            BrBeq:  branchCond = alu_bea;
            BrBne:  branchCond = ~alu_bea;
            BrBgt:  branchCond = ~alu_bga & ~alu_bea;
            BrBge:  branchCond = ~alu_bga;
            BrBlt:  branchCond = alu_bga;
            BrBle:  branchCond = alu_bga | alu_bea;
            BrJump: branchCond = 1'b1;
            default: branchCond = 1'b0;
        endcase
    end

    // Skid buffer next-state: main is always the head, skid only holds the second beat
    always_comb begin
        state_d      = state_q;
        mainResult_d = mainResult_q;
        mainDreg_d   = mainDreg_q;
        mainWe_d     = mainWe_q;
        skidResult_d = skidResult_q;
        skidDreg_d   = skidDreg_q;
        skidWe_d     = skidWe_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d      = StOne;
                    mainResult_d = alu_y;
                    mainDreg_d   = in_dreg;
                    mainWe_d     = storeWe;
                end
            end
            StOne: begin
                if (push && !pop) begin
                    state_d      = StTwo;
                    skidResult_d = alu_y;
                    skidDreg_d   = in_dreg;
                    skidWe_d     = storeWe;
                end else if (push && pop) begin
                    mainResult_d = alu_y;
                    mainDreg_d   = in_dreg;
                    mainWe_d     = storeWe;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    state_d      = StOne;
                    mainResult_d = skidResult_q;
                    mainDreg_d   = skidDreg_q;
                    mainWe_d     = skidWe_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        inReady_d = (state_d != StTwo);
    end

    // Branch resolution: one-cycle pulse, target held until the next taken branch
    always_comb begin
        branchTaken_d = push & branchCond;
        branchAddr_d  = branchAddr_q;
        if (push && branchCond) begin
            branchAddr_d = in_btarget;
        end
    end

    // State registers; an asynchronous reset drops any buffered beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StEmpty;
            inReady_q     <= 1'b1;
            mainResult_q  <= '0;
            mainDreg_q    <= '0;
            mainWe_q      <= 1'b0;
            skidResult_q  <= '0;
            skidDreg_q    <= '0;
            skidWe_q      <= 1'b0;
            branchTaken_q <= 1'b0;
            branchAddr_q  <= '0;
        end else begin
            state_q       <= state_d;
            inReady_q     <= inReady_d;
            mainResult_q  <= mainResult_d;
            mainDreg_q    <= mainDreg_d;
            mainWe_q      <= mainWe_d;
            skidResult_q  <= skidResult_d;
            skidDreg_q    <= skidDreg_d;
            skidWe_q      <= skidWe_d;
            branchTaken_q <= branchTaken_d;
            branchAddr_q  <= branchAddr_d;
        end
    end

    assign in_ready     = inReady_q;
    assign out_result   = mainResult_q;
    assign out_dreg     = mainDreg_q;
    assign out_we       = mainWe_q;
    assign branch_taken = branchTaken_q;
    assign branch_addr  = branchAddr_q;
    assign fwd_valid    = out_valid & mainWe_q;
    assign fwd_dreg     = mainDreg_q;
    assign fwd_data     = mainResult_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage: handshake/ordering sequences, a
// table-driven branch condition sweep, r0/flush handling and async reset.
module tb_ex_mem_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic              flush_in;
    logic [DATA_W-1:0] alu_y;
    logic              alu_bga;
    logic              alu_bea;
    logic [REG_W-1:0]  in_dreg;
    logic              in_we;
    logic [2:0]        in_brop;
    logic [DATA_W-1:0] in_btarget;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [REG_W-1:0]  out_dreg;
    logic              out_we;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_addr;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_dreg;
    logic [DATA_W-1:0] fwd_data;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [2:0] brop;
        logic       bga;
        logic       bea;
        logic       expTaken;
    } branchVec_t;

    branchVec_t vecs[24];

    ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .flush_in(flush_in),
        .alu_y(alu_y), .alu_bga(alu_bga), .alu_bea(alu_bea),
        .in_dreg(in_dreg), .in_we(in_we), .in_brop(in_brop), .in_btarget(in_btarget),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dreg(out_dreg), .out_we(out_we),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .fwd_valid(fwd_valid), .fwd_dreg(fwd_dreg), .fwd_data(fwd_data)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one upstream beat's fields
    task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] y,
                                 input logic [REG_W-1:0] dreg, input logic we,
                                 input logic [2:0] brop, input logic bga, input logic bea,
                                 input logic [DATA_W-1:0] target);
        in_valid   = valid;
        alu_y      = y;
        in_dreg    = dreg;
        in_we      = we;
        in_brop    = brop;
        alu_bga    = bga;
        alu_bea    = bea;
        in_btarget = target;
    endtask

    // Advance to just after the next rising edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInput();
        applyStimulus(1'b0, '0, '0, 1'b0, 3'b000, 1'b0, 1'b0, '0);
    endtask

    initial begin
        // Branch condition table, flag pairs (bga,bea) = 00, 10, 01 per opcode
        vecs[0]  = '{3'b000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{3'b001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b001, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{3'b010, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'b010, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{3'b010, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{3'b011, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'b011, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'b011, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{3'b100, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{3'b100, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{3'b100, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{3'b101, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{3'b101, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{3'b101, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{3'b110, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{3'b110, 1'b1, 1'b0, 1'b1};
        vecs[20] = '{3'b110, 1'b0, 1'b1, 1'b1};
        vecs[21] = '{3'b111, 1'b0, 1'b0, 1'b1};
        vecs[22] = '{3'b111, 1'b1, 1'b0, 1'b1};
        vecs[23] = '{3'b111, 1'b0, 1'b1, 1'b1};

        reset_n   = 1'b0;
        flush_in  = 1'b0;
        out_ready = 1'b1;
        idleInput();
        #12;
        reset_n = 1'b1;
        stepCycle();

        // Reset state
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst out_result", out_result, 32'd0);
        checkOutput("rst branch_taken", 32'(branch_taken), 32'd0);
        checkOutput("rst branch_addr", branch_addr, 32'd0);
        checkOutput("rst fwd_valid", 32'(fwd_valid), 32'd0);

        // Single beat, latency 1, then drains
        applyStimulus(1'b1, 32'h12345678, 4'd3, 1'b1, 3'b000, 1'b0, 1'b0, '0);
        stepCycle();
        idleInput();
        checkOutput("single out_valid", 32'(out_valid), 32'd1);
        checkOutput("single out_result", out_result, 32'h12345678);
        checkOutput("single out_we", 32'(out_we), 32'd1);
        checkOutput("single fwd_valid", 32'(fwd_valid), 32'd1);
        checkOutput("single fwd_dreg", 32'(fwd_dreg), 32'd3);
        checkOutput("single fwd_data", fwd_data, 32'h12345678);
        stepCycle();
        checkOutput("single drained", 32'(out_valid), 32'd0);

        // Fill to TWO with downstream stalled, then drain in order
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'd1, 4'd1, 1'b1, 3'b000, 1'b0, 1'b0, '0);
        stepCycle();
        checkOutput("fill1 in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 32'd2, 4'd2, 1'b1, 3'b000, 1'b0, 1'b0, '0);
        stepCycle();
        idleInput();
        checkOutput("fill2 in_ready", 32'(in_ready), 32'd0);
        checkOutput("fill2 head", out_result, 32'd1);
        stepCycle();
        checkOutput("stall head held", out_result, 32'd1);
        out_ready = 1'b1;
        stepCycle();
        checkOutput("drain second", out_result, 32'd2);
        checkOutput("drain second dreg", 32'(out_dreg), 32'd2);
        checkOutput("drain in_ready", 32'(in_ready), 32'd1);
        checkOutput("drain valid", 32'(out_valid), 32'd1);
        stepCycle();
        checkOutput("drain empty", 32'(out_valid), 32'd0);

        // BGT taken, then BGT with bea=1 not taken; address holds
        applyStimulus(1'b1, 32'd0, 4'd0, 1'b0, 3'b011, 1'b0, 1'b0, 32'h200);
        stepCycle();
        idleInput();
        checkOutput("bgt taken", 32'(branch_taken), 32'd1);
        checkOutput("bgt addr", branch_addr, 32'h200);
        stepCycle();
        checkOutput("bgt pulse end", 32'(branch_taken), 32'd0);
        checkOutput("bgt addr held", branch_addr, 32'h200);
        applyStimulus(1'b1, 32'd0, 4'd0, 1'b0, 3'b011, 1'b0, 1'b1, 32'h300);
        stepCycle();
        idleInput();
        checkOutput("bgt eq not taken", 32'(branch_taken), 32'd0);
        checkOutput("bgt eq addr held", branch_addr, 32'h200);
        stepCycle();

        // Back-to-back branch sweep; also checks one-per-cycle throughput
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, 32'(i + 100), 4'd5, 1'b1, vecs[i].brop,
                          vecs[i].bga, vecs[i].bea, 32'(32'h1000 + i));
            stepCycle();
            checkOutput($sformatf("sweep%0d taken", i), 32'(branch_taken), 32'(vecs[i].expTaken));
            if (vecs[i].expTaken) begin
                checkOutput($sformatf("sweep%0d addr", i), branch_addr, 32'(32'h1000 + i));
            end
            checkOutput($sformatf("sweep%0d result", i), out_result, 32'(i + 100));
            checkOutput($sformatf("sweep%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        idleInput();
        stepCycle();
        checkOutput("sweep drained", 32'(out_valid), 32'd0);

        // Write to r0 is suppressed
        applyStimulus(1'b1, 32'hABCD, 4'd0, 1'b1, 3'b000, 1'b0, 1'b0, '0);
        stepCycle();
        idleInput();
        checkOutput("r0 out_valid", 32'(out_valid), 32'd1);
        checkOutput("r0 out_we", 32'(out_we), 32'd0);
        checkOutput("r0 fwd_valid", 32'(fwd_valid), 32'd0);
        stepCycle();

        // Flushed JUMP beat: accepted but neither stored nor resolved
        applyStimulus(1'b1, 32'h55, 4'd7, 1'b1, 3'b111, 1'b0, 1'b0, 32'h900);
        flush_in = 1'b1;
        checkOutput("flush in_ready", 32'(in_ready), 32'd1);
        stepCycle();
        idleInput();
        flush_in = 1'b0;
        checkOutput("flush out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush no branch", 32'(branch_taken), 32'd0);
        checkOutput("flush addr held", branch_addr, 32'h1017);

        // Async reset while holding two beats and a pending branch pulse
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h77, 4'd4, 1'b1, 3'b000, 1'b0, 1'b0, '0);
        stepCycle();
        applyStimulus(1'b1, 32'h88, 4'd6, 1'b1, 3'b111, 1'b0, 1'b0, 32'h440);
        stepCycle();
        idleInput();
        checkOutput("pre-rst in_ready", 32'(in_ready), 32'd0);
        checkOutput("pre-rst branch", 32'(branch_taken), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async out_valid", 32'(out_valid), 32'd0);
        checkOutput("async in_ready", 32'(in_ready), 32'd1);
        checkOutput("async out_result", out_result, 32'd0);
        checkOutput("async out_dreg", 32'(out_dreg), 32'd0);
        checkOutput("async out_we", 32'(out_we), 32'd0);
        checkOutput("async branch", 32'(branch_taken), 32'd0);
        checkOutput("async branch_addr", branch_addr, 32'd0);
        checkOutput("async fwd_valid", 32'(fwd_valid), 32'd0);
        #10;
        reset_n = 1'b1;
        out_ready = 1'b1;
        stepCycle();
        checkOutput("post-rst empty", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Pipeline stage directly downstream of the CPU ALU. It captures the ALU result and comparison flags (b>a, b==a) with the instruction's destination register and branch info. It resolves conditional branches from the flags and buffers results for the memory/writeback stage in a 2-entry skid buffer with valid/ready handshakes. It also exposes the head entry for operand forwarding back to the execute stage.

Parameters:
DATA_W, 32, width of ALU result and branch target
REG_W, 4, destination register index width (16 registers, r0 hard-wired zero)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat this cycle
flush_in  in  1  discard the incoming beat this cycle
alu_y  in  DATA_W  ALU result
alu_bga  in  1  ALU flag b>a
alu_bea  in  1  ALU flag b==a
in_dreg  in  REG_W  destination register
in_we  in  1  register write enable
in_brop  in  3  branch op: 000 none, 001 BEQ, 010 BNE, 011 BGT, 100 BGE, 101 BLT, 110 BLE, 111 JUMP
in_btarget  in  DATA_W  branch target address
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts beat
out_result  out  DATA_W  head result
out_dreg  out  REG_W  head destination
out_we  out  1  head write enable
branch_taken  out  1  one-cycle pulse: branch resolved taken
branch_addr  out  DATA_W  target for branch_taken
fwd_valid  out  1  head holds a pending register write
fwd_dreg  out  REG_W  forwarding register index
fwd_data  out  DATA_W  forwarding data

Behaviour:
- Reset (async, reset_n=0): buffer EMPTY, out_valid=0, out_result=0, out_dreg=0, out_we=0, branch_taken=0, branch_addr=0, fwd_valid=0, in_ready=1. The reset takes effect mid-transfer; buffered beats are lost.
- Accept: push = in_valid & in_ready & !flush_in. When flush_in=1 the beat is consumed (handshake completes), nothing is stored, and no branch is resolved.
- Pop: out_valid & out_ready.
- Buffer states: EMPTY, ONE (main only), TWO (main + skid). in_ready is registered and equals (next state != TWO).
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> TWO. pop & !push -> EMPTY. push & pop -> ONE, and main takes the new beat.
  - TWO: pop -> ONE, and skid moves to main. No push is possible.
- FIFO ordering is strict. The head is always main. out_* are driven straight from main registers (no combinational input->output path).
- Stored we = in_we & (in_dreg != 0). Writes to r0 are never emitted.
- Branch condition, evaluated on push only:
  - BEQ: bea
  - BNE: !bea
  - BGT (a>b): !bga & !bea
  - BGE: !bga
  - BLT: bga
  - BLE: bga | bea
  - JUMP: 1
  - none: 0
- Branch timing:
  - branch_taken=1 exactly one cycle after a push with a true condition, with branch_addr=in_btarget of that beat.
  - branch_addr holds its value until the next taken branch.
  - branch_taken is 0 on every other cycle.
  - Branch beats are still stored so that link writes (in_we) complete.
- Forwarding: fwd_valid = out_valid & out_we, fwd_dreg = out_dreg, fwd_data = out_result.
- Back-to-back throughput: one beat per cycle when out_ready is held 1. Latency is 1 cycle from push to out_valid.

Test Plan:
- Reset then push alu_y=0x12345678, dreg=3, we=1, out_ready=1 -> next cycle out_valid=1, out_result=0x12345678, out_we=1, fwd_valid=1; buffer drains the cycle after.
- out_ready=0, push beats A=1, B=2 -> in_ready=0 after the second push. Then set out_ready=1 -> out_result=1 then 2 on consecutive cycles, and in_ready returns to 1.
- Push BGT with bga=0, bea=0, btarget=0x200 -> branch_taken pulses one cycle, branch_addr=0x200. Repeat with bea=1 -> no pulse.
- Sweep all 8 brop codes against the flag pairs (bga,bea) in {00, 10, 01} -> branch_taken matches the condition table.
- Push dreg=0, we=1 -> out_we=0, fwd_valid=0. Push with flush_in=1 -> handshake completes, out_valid stays 0, no branch pulse.
- Deassert reset_n asynchronously while the buffer is in TWO -> all outputs are 0 immediately and in_ready=1.
